// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters (0: core
//   datapath, 1: auxiliary unit). One op in flight: accept (IDLE), drive the ALU
//   for one cycle (EXEC), then hold the registered result until the owner takes
//   it (RESP).
//   Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win
//   ties. Without it, ties alternate round-robin.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready [1:0]       op request handshake, one bit per requester
//   req_a*/req_b*/req_op*           operands and ALU control per requester
//   resp_valid/resp_ready [1:0]     result handshake, one bit per requester
//   resp_result, resp_z             registered ALU result and flag (shared bus)
//   alu_srca/alu_srcb/alu_ctrl      to the shared ALU
//   alu_result/alu_flag             from the shared ALU (same cycle)
//   op_cnt0/op_cnt1                 saturating completed-op counters
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OP_W-1:0]  req_op0,
  input  logic [OP_W-1:0]  req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_z,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  output logic [CNT_W-1:0] op_cnt0,
  output logic [CNT_W-1:0] op_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;
  logic             owner;
  logic             accept;
  logic             release_op;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic [OP_W-1:0]  opnd_op;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             rr_last;
`endif

  // Arbitration: a single requester always wins; ties resolved by build option.
  always_comb begin
    grant = ~req_valid[0];
`ifndef ALU_ARB_FIXED_PRIO_EN
    if (req_valid == 2'b11) begin
      grant = ~rr_last;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    alu_ctrl   = '0;
    accept     = 1'b0;
    release_op = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = grant ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_ctrl  = opnd_op;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        if (resp_ready[owner]) begin
          release_op = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign alu_srca = opnd_a;
  assign alu_srcb = opnd_b;

  // Operand latch, result capture and ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd_a      <= '0;
      opnd_b      <= '0;
      opnd_op     <= '0;
      owner       <= 1'b0;
      resp_result <= '0;
      resp_z      <= 1'b0;
    end else begin
      if (accept) begin
        opnd_a  <= grant ? req_a1  : req_a0;
        opnd_b  <= grant ? req_b1  : req_b0;
        opnd_op <= grant ? req_op1 : req_op0;
        owner   <= grant;
      end
      if (state == S_EXEC) begin
        resp_result <= alu_result;
        resp_z      <= alu_flag;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (release_op) begin
      rr_last <= owner;
    end
  end
`endif

  // Completed-op counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_cnt0 <= '0;
      op_cnt1 <= '0;
    end else if (release_op) begin
      if (!owner && (op_cnt0 != '1)) op_cnt0 <= op_cnt0 + CNT_W'(1);
      if (owner  && (op_cnt1 != '1)) op_cnt1 <= op_cnt1 + CNT_W'(1);
    end
  end

endmodule
